// File: rtl/mat2_job_driver_pkg.sv
// Shared definitions for the 2x2 matrix job driver: FSM encoding,
// operand/result word positions and the default handshake timeout.
package mat2_job_driver_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    localparam int NUM_OPERAND_WORDS = 8;
    localparam int NUM_RESULT_WORDS  = 4;

    // Operand words arrive in this order on the input stream
    localparam logic [2:0] IDX_A11 = 3'd0;
    localparam logic [2:0] IDX_A12 = 3'd1;
    localparam logic [2:0] IDX_A21 = 3'd2;
    localparam logic [2:0] IDX_A22 = 3'd3;
    localparam logic [2:0] IDX_B11 = 3'd4;
    localparam logic [2:0] IDX_B12 = 3'd5;
    localparam logic [2:0] IDX_B21 = 3'd6;
    localparam logic [2:0] IDX_B22 = 3'd7;

    // Result words leave on the output stream in this order
    localparam logic [1:0] IDX_C11 = 2'd0;
    localparam logic [1:0] IDX_C12 = 2'd1;
    localparam logic [1:0] IDX_C21 = 2'd2;
    localparam logic [1:0] IDX_C22 = 2'd3;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT_C = 3'd2,
        ST_ACK    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

endpackage

// File: rtl/mat2_job_driver_hs_watchdog.sv
// Handshake watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle whose edge would complete TIMEOUT_CYCLES of waiting.
module hs_watchdog
    import mat2_job_driver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic input_Clk,
    input  logic input_Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so a stalled phase keeps reporting expiry
    always_ff @(posedge input_Clk or posedge input_Reset) begin
        if (input_Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count >= LAST);

endmodule

// File: rtl/mat2_job_driver.sv
// Streams eight operand words into a 2x2 matrix multiplier, runs its
// four-phase handshake and streams the four result words back out.
module mat2_job_driver
    import mat2_job_driver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        input_Clk,
    input  logic        input_Reset,
    input  logic [31:0] input_Data,
    input  logic        input_Valid,
    output logic        output_Ready,
    output logic [31:0] output_Data,
    output logic        output_Valid,
    input  logic        input_Ready,
    output logic [31:0] output_A11,
    output logic [31:0] output_A12,
    output logic [31:0] output_A21,
    output logic [31:0] output_A22,
    output logic [31:0] output_B11,
    output logic [31:0] output_B12,
    output logic [31:0] output_B21,
    output logic [31:0] output_B22,
    output logic        output_AB_Stable,
    input  logic        input_AB_Ack,
    input  logic [31:0] input_C11,
    input  logic [31:0] input_C12,
    input  logic [31:0] input_C21,
    input  logic [31:0] input_C22,
    input  logic        input_C_Stable,
    output logic        output_C_Ack,
    output logic [15:0] output_Jobs,
    output logic        output_Error
);

    state_t      state;
    logic [2:0]  load_idx;
    logic [1:0]  drain_idx;
    logic [31:0] operand [NUM_OPERAND_WORDS];
    logic [31:0] result  [NUM_RESULT_WORDS];

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    assign output_A11 = operand[IDX_A11];
    assign output_A12 = operand[IDX_A12];
    assign output_A21 = operand[IDX_A21];
    assign output_A22 = operand[IDX_A22];
    assign output_B11 = operand[IDX_B11];
    assign output_B12 = operand[IDX_B12];
    assign output_B21 = operand[IDX_B21];
    assign output_B22 = operand[IDX_B22];

    // Any handshake progress restarts the count, so progress beats a timeout
    always_comb begin
        wd_enable = (state == ST_ISSUE) || (state == ST_WAIT_C) || (state == ST_ACK);
        wd_clear  = !wd_enable
                 || ((state == ST_ISSUE)  && input_AB_Ack)
                 || ((state == ST_WAIT_C) && input_C_Stable)
                 || ((state == ST_ACK)    && !input_C_Stable);
    end

    hs_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .input_Clk  (input_Clk),
        .input_Reset(input_Reset),
        .clear      (wd_clear),
        .enable     (wd_enable),
        .expired    (wd_expired)
    );

    always_ff @(posedge input_Clk or posedge input_Reset) begin
        if (input_Reset) begin
            state            <= ST_LOAD;
            load_idx         <= '0;
            drain_idx        <= '0;
            for (int i = 0; i < NUM_OPERAND_WORDS; i++) operand[i] <= '0;
            for (int i = 0; i < NUM_RESULT_WORDS; i++)  result[i]  <= '0;
            output_Ready     <= 1'b0;
            output_Data      <= '0;
            output_Valid     <= 1'b0;
            output_AB_Stable <= 1'b0;
            output_C_Ack     <= 1'b0;
            output_Jobs      <= '0;
            output_Error     <= 1'b0;
        end else if (wd_expired && !wd_clear) begin
            state            <= ST_ERROR;
            output_Error     <= 1'b1;
            output_Ready     <= 1'b0;
            output_Valid     <= 1'b0;
            output_AB_Stable <= 1'b0;
            output_C_Ack     <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (input_Valid && output_Ready) begin
                        operand[load_idx] <= input_Data;
                        if (load_idx == IDX_B22) begin
                            load_idx         <= '0;
                            output_Ready     <= 1'b0;
                            output_AB_Stable <= 1'b1;
                            state            <= ST_ISSUE;
                        end else begin
                            load_idx     <= load_idx + 3'd1;
                            output_Ready <= 1'b1;
                        end
                    end else begin
                        output_Ready <= 1'b1;
                    end
                end

                // A result strobe seen here is deliberately ignored until WAIT_C
                ST_ISSUE: begin
                    if (input_AB_Ack) begin
                        output_AB_Stable <= 1'b0;
                        state            <= ST_WAIT_C;
                    end
                end

                ST_WAIT_C: begin
                    if (input_C_Stable) begin
                        result[IDX_C11] <= input_C11;
                        result[IDX_C12] <= input_C12;
                        result[IDX_C21] <= input_C21;
                        result[IDX_C22] <= input_C22;
                        output_C_Ack    <= 1'b1;
                        state           <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    if (!input_C_Stable) begin
                        output_C_Ack <= 1'b0;
                        output_Valid <= 1'b1;
                        output_Data  <= result[IDX_C11];
                        drain_idx    <= IDX_C11;
                        state        <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (input_Ready) begin
                        if (drain_idx == IDX_C22) begin
                            output_Valid <= 1'b0;
                            output_Data  <= '0;
                            output_Jobs  <= output_Jobs + 16'd1;
                            output_Ready <= 1'b1;
                            drain_idx    <= '0;
                            state        <= ST_LOAD;
                        end else begin
                            drain_idx   <= drain_idx + 2'd1;
                            output_Data <= result[drain_idx + 2'd1];
                        end
                    end
                end

                // Sticky until reset; every handshake output stays low
                ST_ERROR: begin
                    output_Error     <= 1'b1;
                    output_Ready     <= 1'b0;
                    output_Valid     <= 1'b0;
                    output_AB_Stable <= 1'b0;
                    output_C_Ack     <= 1'b0;
                end

                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/mat2_job_driver.md
MAT2_JOB_DRIVER -- requirements
Module: mat2_job_driver

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, the maximum cycles to wait on any multiplier handshake phase.
REQ-002 The block SHALL have port input_Clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port input_Reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port input_Data, input, 32, the operand word stream.
REQ-005 The block SHALL have port input_Valid, input, 1, meaning input_Data is valid.
REQ-006 The block SHALL have port output_Ready, output, 1, meaning the block accepts an operand word.
REQ-007 The block SHALL have port output_Data, output, 32, the result word stream.
REQ-008 The block SHALL have port output_Valid, output, 1, meaning output_Data is valid.
REQ-009 The block SHALL have port input_Ready, input, 1, meaning the downstream sink accepts a result word.
REQ-010 The block SHALL have ports output_A11/A12/A21/A22 and output_B11/B12/B21/B22, output, 32 each, the operands presented to the multiplier.
REQ-011 The block SHALL have port output_AB_Stable, output, 1, meaning the operands are valid.
REQ-012 The block SHALL have port input_AB_Ack, input, 1, the multiplier's operand acknowledge.
REQ-013 The block SHALL have ports input_C11/C12/C21/C22, input, 32 each, the multiplier results.
REQ-014 The block SHALL have port input_C_Stable, input, 1, meaning the results are valid.
REQ-015 The block SHALL have port output_C_Ack, output, 1, the result acknowledge to the multiplier.
REQ-016 The block SHALL have port output_Jobs, output, 16, the count of completed jobs.
REQ-017 The block SHALL have port output_Error, output, 1, a sticky handshake-timeout flag.

Function
REQ-018 The block SHALL implement states LOAD, ISSUE, WAIT_C, ACK, DRAIN and ERROR, with all outputs registered.
REQ-019 In LOAD, output_Ready SHALL be 1 and a word SHALL be accepted on each edge where input_Valid&&output_Ready, filling A11,A12,A21,A22,B11,B12,B21,B22 in that order.
REQ-020 On the 8th accepted word, the next state SHALL be ISSUE: output_Ready=0 and output_AB_Stable=1 from the following cycle.
REQ-021 Operand outputs SHALL hold stable from ISSUE until the return to LOAD.
REQ-022 In ISSUE, when input_AB_Ack is sampled 1, output_AB_Stable SHALL be 0 on the next edge and the state SHALL become WAIT_C.
REQ-023 In WAIT_C, when input_C_Stable is sampled 1, the block SHALL capture C11..C22, set output_C_Ack=1, and go to ACK.
REQ-024 If input_C_Stable is already 1 in ISSUE, the block SHALL ignore it until WAIT_C.
REQ-025 In ACK, output_C_Ack SHALL remain 1 until input_C_Stable is sampled 0; it SHALL then go to 0 and the state SHALL become DRAIN.
REQ-026 In DRAIN, output_Valid SHALL be 1 with output_Data = captured C11,C12,C21,C22 in order, advancing on each edge where input_Ready=1.
REQ-027 After the 4th result transfer, output_Jobs SHALL increment (wrapping 0xFFFF to 0x0000) and the state SHALL return to LOAD.
REQ-028 A wait counter SHALL clear on entry to each of ISSUE, WAIT_C and ACK and count every cycle spent there; at TIMEOUT_CYCLES the state SHALL become ERROR.
REQ-029 In ERROR, output_Error SHALL be 1 and output_Ready, output_Valid, output_AB_Stable and output_C_Ack SHALL be 0, until reset.
REQ-030 input_Valid outside LOAD and input_Ready outside DRAIN SHALL be ignored.

Reset
REQ-031 Reset SHALL clear all outputs, operand/result registers, the word index, the wait counter and output_Jobs to 0, and set state to LOAD, asynchronously.
REQ-032 Reset asserted mid-job SHALL abandon the job; after reset release, the first accepted word SHALL be A11.

Structure
REQ-033 A shared package SHALL hold the state encoding, the operand/result word-index constants, and the TIMEOUT_CYCLES default.
REQ-034 The wait counter SHALL be a sub-module hs_watchdog (inputs clear/enable, output expired).

Verification
REQ-035 Identity job: stream A=1.0,2.0,3.0,4.0 and B=identity with a model multiplier -> output_Data 0x3F800000, 0x40000000, 0x40400000, 0x40800000; output_Jobs=1.
REQ-036 Backpressure: input_Ready toggling 1/0 each cycle during DRAIN -> same 4 words in order, none duplicated or dropped.
REQ-037 Early C: model asserts input_C_Stable in the same cycle as input_AB_Ack -> C captured in WAIT_C and output_C_Ack held until input_C_Stable falls.
REQ-038 Timeout: TIMEOUT_CYCLES=16 and the model never acks -> output_Error=1 exactly 16 cycles after output_AB_Stable rises; all handshake outputs 0.
REQ-039 Reset mid-load after 5 words -> all outputs 0; a new 8-word job then completes correctly.
REQ-040 Wrap: preload 65535 jobs (or force the counter) and run one more job -> output_Jobs=0x0000.
